// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - alarm clock FSM with ring timeout, snooze budget and LED chaser
module alarm_controller #(
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_S       = 300,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic [4:0] cur_hrs,
    input  logic [5:0] cur_min,
    input  logic [4:0] alm_hrs,
    input  logic [5:0] alm_min,
    input  logic       arm_en,
    input  logic       stop,
    input  logic       snooze,
    output logic [1:0] state,
    output logic       ringing,
    output logic [4:0] leds,
    output logic [1:0] snooze_left
);

    typedef enum logic [1:0] {
        DISABLED = 2'b00,
        ARMED    = 2'b01,
        RINGING  = 2'b10,
        SNOOZING = 2'b11
    } state_t;

    localparam logic [15:0] RING_LOAD   = 16'(RING_TIMEOUT_S);
    localparam logic [15:0] SNOOZE_LOAD = 16'(SNOOZE_S);
    localparam logic [1:0]  SNOOZE_MAX  = 2'(MAX_SNOOZE);

    state_t      st;
    logic [15:0] timer;
    logic        match;
    logic        match_q;
    logic        stop_q;
    logic        snooze_q;
    logic        trigger;
    logic        stop_p;
    logic        snooze_p;
    logic        last_tick;

    // An out-of-range alarm time can never match, even if the current time echoes it.
    always_comb begin
        match = (alm_hrs < 5'd24) && (alm_min < 6'd60) &&
                ({cur_hrs, cur_min} == {alm_hrs, alm_min});
    end

    assign trigger   = match & ~match_q;
    assign stop_p    = stop & ~stop_q;
    assign snooze_p  = snooze & ~snooze_q;
    assign last_tick = (timer <= 16'd1);

    assign state   = st;
    assign ringing = (st == RINGING);

    // Edge-history registers plus the alarm state machine, its timer, snooze budget and LEDs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= DISABLED;
            timer       <= 16'd0;
            snooze_left <= 2'd0;
            leds        <= 5'b00000;
            match_q     <= 1'b0;
            stop_q      <= 1'b0;
            snooze_q    <= 1'b0;
        end else begin
            match_q  <= match;
            stop_q   <= stop;
            snooze_q <= snooze;

            if (!arm_en) begin
                st   <= DISABLED;
                leds <= 5'b00000;
            end else begin
                case (st)
                    DISABLED: begin
                        st          <= ARMED;
                        snooze_left <= SNOOZE_MAX;
                    end
                    ARMED: begin
                        if (trigger) begin
                            st    <= RINGING;
                            timer <= RING_LOAD;
                            leds  <= 5'b00001;
                        end
                    end
                    RINGING: begin
                        if (stop_p) begin
                            st          <= ARMED;
                            snooze_left <= SNOOZE_MAX;
                            leds        <= 5'b00000;
                        end else if (snooze_p && snooze_left != 2'd0) begin
                            st          <= SNOOZING;
                            timer       <= SNOOZE_LOAD;
                            snooze_left <= snooze_left - 2'd1;
                            leds        <= 5'b00000;
                        end else if (tick_1hz) begin
                            timer <= (timer == 16'd0) ? 16'd0 : timer - 16'd1;
                            if (last_tick) begin
                                st          <= ARMED;
                                snooze_left <= SNOOZE_MAX;
                                leds        <= 5'b00000;
                            end else begin
                                leds <= {leds[3:0], leds[4]};
                            end
                        end
                    end
                    SNOOZING: begin
                        if (stop_p) begin
                            st          <= ARMED;
                            snooze_left <= SNOOZE_MAX;
                        end else if (tick_1hz) begin
                            if (last_tick) begin
                                st    <= RINGING;
                                timer <= RING_LOAD;
                                leds  <= 5'b00001;
                            end else begin
                                timer <= timer - 16'd1;
                            end
                        end
                    end
                    default: st <= DISABLED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alarm_controller.sv
// tb/tb_alarm_controller.sv - scoreboard bench for alarm_controller
module tb_alarm_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz;
    logic [4:0] cur_hrs;
    logic [5:0] cur_min;
    logic [4:0] alm_hrs;
    logic [5:0] alm_min;
    logic       arm_en;
    logic       stop;
    logic       snooze;
    logic [1:0] state;
    logic       ringing;
    logic [4:0] leds;
    logic [1:0] snooze_left;

    int checks   = 0;
    int failures = 0;

    logic [9:0] exp_q[$];
    string      name_q[$];
    event       sample_now;

    alarm_controller #(
        .RING_TIMEOUT_S(4),
        .SNOOZE_S      (3),
        .MAX_SNOOZE    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .cur_hrs    (cur_hrs),
        .cur_min    (cur_min),
        .alm_hrs    (alm_hrs),
        .alm_min    (alm_min),
        .arm_en     (arm_en),
        .stop       (stop),
        .snooze     (snooze),
        .state      (state),
        .ringing    (ringing),
        .leds       (leds),
        .snooze_left(snooze_left)
    );

    always #5 clk = ~clk;

    // expected = {state, ringing, leds, snooze_left}
    task automatic expect_out(input string nm, input logic [1:0] st, input logic rg,
                              input logic [4:0] ld, input logic [1:0] sl);
        exp_q.push_back({st, rg, ld, sl});
        name_q.push_back(nm);
    endtask

    // one clock edge, then drive/settle 1 ns after it
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
    endtask

    task automatic set_cur(input logic [4:0] h, input logic [5:0] m);
        cur_hrs = h;
        cur_min = m;
    endtask

    // Monitor: compare one pending expectation on each falling edge or immediate request.
    initial begin
        logic [9:0] got;
        logic [9:0] exp;
        string      nm;
        forever begin
            @(negedge clk or sample_now);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                got = {state, ringing, leds, snooze_left};
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL %s: got state=%b ringing=%b leds=%b snooze_left=%b, expected state=%b ringing=%b leds=%b snooze_left=%b",
                             nm, got[9:8], got[7], got[6:2], got[1:0], exp[9:8], exp[7], exp[6:2], exp[1:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached, expected stimulus to complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rst = 1'b1; tick_1hz = 1'b0; arm_en = 1'b0; stop = 1'b0; snooze = 1'b0;
        alm_hrs = 5'd7; alm_min = 6'd30;
        set_cur(5'd0, 6'd0);
        cyc();
        expect_out("reset", 2'b00, 1'b0, 5'b00000, 2'd0);
        rst = 1'b0;

        // basic ring and timeout
        arm_en = 1'b1; set_cur(5'd7, 6'd29);
        cyc(); expect_out("arm", 2'b01, 1'b0, 5'b00000, 2'd2);
        set_cur(5'd7, 6'd30);
        cyc(); expect_out("ring_start", 2'b10, 1'b1, 5'b00001, 2'd2);
        tick(); expect_out("tick1", 2'b10, 1'b1, 5'b00010, 2'd2);
        tick(); expect_out("tick2", 2'b10, 1'b1, 5'b00100, 2'd2);
        tick(); expect_out("tick3", 2'b10, 1'b1, 5'b01000, 2'd2);
        tick(); expect_out("timeout", 2'b01, 1'b0, 5'b00000, 2'd2);
        cyc(); expect_out("no_retrigger", 2'b01, 1'b0, 5'b00000, 2'd2);

        // snooze exhaustion
        set_cur(5'd7, 6'd31);
        cyc(); expect_out("leave_minute", 2'b01, 1'b0, 5'b00000, 2'd2);
        set_cur(5'd7, 6'd30);
        cyc(); expect_out("ring_again", 2'b10, 1'b1, 5'b00001, 2'd2);
        snooze = 1'b1;
        cyc(); expect_out("snooze1", 2'b11, 1'b0, 5'b00000, 2'd1);
        snooze = 1'b0;
        tick(); expect_out("snz_t1", 2'b11, 1'b0, 5'b00000, 2'd1);
        tick(); expect_out("snz_t2", 2'b11, 1'b0, 5'b00000, 2'd1);
        tick(); expect_out("snz_end", 2'b10, 1'b1, 5'b00001, 2'd1);
        snooze = 1'b1;
        cyc(); expect_out("snooze2", 2'b11, 1'b0, 5'b00000, 2'd0);
        snooze = 1'b0;
        tick(); expect_out("snz2_t1", 2'b11, 1'b0, 5'b00000, 2'd0);
        tick(); expect_out("snz2_t2", 2'b11, 1'b0, 5'b00000, 2'd0);
        tick(); expect_out("snz2_end", 2'b10, 1'b1, 5'b00001, 2'd0);
        snooze = 1'b1;
        cyc(); expect_out("snooze3_ignored", 2'b10, 1'b1, 5'b00001, 2'd0);
        snooze = 1'b0;

        // stop + snooze + tick together: stop wins
        stop = 1'b1; snooze = 1'b1; tick_1hz = 1'b1;
        cyc(); expect_out("prio_stop", 2'b01, 1'b0, 5'b00000, 2'd2);
        stop = 1'b0; snooze = 1'b0; tick_1hz = 1'b0;
        cyc(); expect_out("prio_settle", 2'b01, 1'b0, 5'b00000, 2'd2);

        // disarm in the same cycle as a trigger
        set_cur(5'd7, 6'd31);
        cyc(); expect_out("pre_disarm", 2'b01, 1'b0, 5'b00000, 2'd2);
        set_cur(5'd7, 6'd30); arm_en = 1'b0;
        cyc(); expect_out("disarm_over_trigger", 2'b00, 1'b0, 5'b00000, 2'd2);
        cyc(); expect_out("disarm_hold", 2'b00, 1'b0, 5'b00000, 2'd2);

        // arm inside the matching minute
        alm_hrs = 5'd12; alm_min = 6'd0; set_cur(5'd12, 6'd0);
        cyc(); expect_out("match_disabled", 2'b00, 1'b0, 5'b00000, 2'd2);
        arm_en = 1'b1;
        cyc(); expect_out("arm_in_match", 2'b01, 1'b0, 5'b00000, 2'd2);
        cyc(); expect_out("arm_in_match_hold", 2'b01, 1'b0, 5'b00000, 2'd2);
        set_cur(5'd12, 6'd1);
        cyc(); expect_out("minute_1201", 2'b01, 1'b0, 5'b00000, 2'd2);
        set_cur(5'd12, 6'd0);
        cyc(); expect_out("next_day_ring", 2'b10, 1'b1, 5'b00001, 2'd2);

        // async reset mid-snooze
        snooze = 1'b1;
        cyc(); expect_out("snooze_before_rst", 2'b11, 1'b0, 5'b00000, 2'd1);
        snooze = 1'b0;
        cyc(); expect_out("snoozing", 2'b11, 1'b0, 5'b00000, 2'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 expect_out("async_reset", 2'b00, 1'b0, 5'b00000, 2'd0);
        -> sample_now;
        cyc(); expect_out("reset_held", 2'b00, 1'b0, 5'b00000, 2'd0);
        rst = 1'b0;
        cyc(); expect_out("rearm_after_rst", 2'b01, 1'b0, 5'b00000, 2'd2);

        // invalid alarm hour: even an identical current time must not ring
        alm_hrs = 5'd25; alm_min = 6'd0; set_cur(5'd24, 6'd59);
        cyc(); expect_out("bad_hr_pre", 2'b01, 1'b0, 5'b00000, 2'd2);
        set_cur(5'd25, 6'd0);
        cyc(); expect_out("bad_hr_match", 2'b01, 1'b0, 5'b00000, 2'd2);
        cyc(); expect_out("bad_hr_hold", 2'b01, 1'b0, 5'b00000, 2'd2);

        // invalid alarm minute
        alm_hrs = 5'd10; alm_min = 6'd60; set_cur(5'd10, 6'd59);
        cyc(); expect_out("bad_min_pre", 2'b01, 1'b0, 5'b00000, 2'd2);
        set_cur(5'd10, 6'd60);
        cyc(); expect_out("bad_min_match", 2'b01, 1'b0, 5'b00000, 2'd2);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending expectations=%0d, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
